sc_reg_lane_shifter: RTL and testbench

Parametrised one-hot position register for the player car's lane, the next generation of the 4-bit lane shifter. It adds configurable width and reset lane, tick-gated auto-repeat for held steering inputs, and validated loads. It reports limit flags and move events. It sits between the debounced steering inputs and the collision/draw logic of the game datapath.

---
 rtl/sc_reg_lane_shifter.sv | 237 +++++++++++++++++++++++
 tb/tb_sc_reg_lane_shifter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_reg_lane_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : sc_reg_lane_shifter
//  Brief    : One-hot lane register for the player car. Supports a
//             parametrised lane count and reset lane, tick-gated auto-repeat
//             for held steering, and validated one-hot loads. Reports
//             edge-lane flags, move pulses and load-reject pulses.
//             Optional build macro: SC_REGLANE_WRAP_EN (edge shifts wrap
//             around instead of saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module sc_reg_lane_shifter #(
  parameter int RegLANE_DATAWIDTH     = 8,
  parameter int RegLANE_INIT_POS      = 3,
  parameter int RegLANE_REPEAT_DELAY  = 16,
  parameter int RegLANE_REPEAT_PERIOD = 4
) (
  input  logic                         SC_RegLANE_CLOCK_50,
  input  logic                         SC_RegLANE_RESET_InLow,
  input  logic                         SC_RegLANE_clear_InLow,
  input  logic                         SC_RegLANE_load_InLow,
  input  logic                         SC_RegLANE_enable_In,
  input  logic [1:0]                   SC_RegLANE_shiftselection_In,
  input  logic [RegLANE_DATAWIDTH-1:0] SC_RegLANE_data_InBUS,
  output logic [RegLANE_DATAWIDTH-1:0] SC_RegLANE_data_OutBUS,
  output logic                         SC_RegLANE_moved_Out,
  output logic [1:0]                   SC_RegLANE_atlimit_Out,
  output logic                         SC_RegLANE_loaderr_Out
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  // The repeat counter only has to reach the larger of the two intervals
  // minus one; a single-cycle interval still needs a one-bit counter.
  localparam int c_CNT_MAX = (RegLANE_REPEAT_DELAY > RegLANE_REPEAT_PERIOD) ?
                             RegLANE_REPEAT_DELAY : RegLANE_REPEAT_PERIOD;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(RegLANE_REPEAT_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(RegLANE_REPEAT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO    = '0;

  localparam logic [RegLANE_DATAWIDTH-1:0] c_INIT_VEC =
    RegLANE_DATAWIDTH'(1) << RegLANE_INIT_POS;

  localparam logic [1:0] c_SEL_LEFT  = 2'b01;
  localparam logic [1:0] c_SEL_RIGHT = 2'b10;
  localparam logic [1:0] c_SEL_NONE  = 2'b00;

  // --------------------------------------------------------------------------
  // Shift FSM encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for a fresh steering request
    ST_HOLD   = 2'd1,  // request held, counting the initial repeat delay
    ST_REPEAT = 2'd2,  // auto-repeating at the repeat period
    ST_LOCK   = 2'd3   // after clear/load: ignore steering until released
  } laneState_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [RegLANE_DATAWIDTH-1:0] r_lanePos;
  logic                         r_moved;
  logic                         r_loadErr;
  laneState_t                   r_state;
  logic [c_CNT_W-1:0]           r_repeatCnt;
  logic [1:0]                   r_dirLatched;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                         w_selLeft;
  logic                         w_selRight;
  logic                         w_selValid;
  logic                         w_dirChange;
  logic                         w_loadOneHot;
  logic [RegLANE_DATAWIDTH-1:0] w_loadMinusOne;
  logic [RegLANE_DATAWIDTH-1:0] w_shiftVec;
  logic                         w_shiftMoves;

  // Decode the steering selection; 00 and 11 both mean "no request".
  always_comb begin
    w_selLeft   = (SC_RegLANE_shiftselection_In == c_SEL_LEFT);
    w_selRight  = (SC_RegLANE_shiftselection_In == c_SEL_RIGHT);
    w_selValid  = w_selLeft | w_selRight;
    w_dirChange = w_selValid && (SC_RegLANE_shiftselection_In != r_dirLatched);
  end

  // A load value is accepted only when exactly one bit is set (x & (x-1) clears the lowest set bit).
  always_comb begin
    w_loadMinusOne = SC_RegLANE_data_InBUS - RegLANE_DATAWIDTH'(1);
    w_loadOneHot   = (SC_RegLANE_data_InBUS != '0) &&
                     ((SC_RegLANE_data_InBUS & w_loadMinusOne) == '0);
  end

  // Candidate position for a shift in the currently requested direction.
  // w_shiftMoves is low when the shift is swallowed at an edge lane.
  always_comb begin
    w_shiftVec   = r_lanePos;
    w_shiftMoves = 1'b0;
    if (w_selLeft) begin
      if (r_lanePos[RegLANE_DATAWIDTH-1]) begin
`ifdef SC_REGLANE_WRAP_EN
        w_shiftVec   = {r_lanePos[RegLANE_DATAWIDTH-2:0], r_lanePos[RegLANE_DATAWIDTH-1]};
        w_shiftMoves = 1'b1;
`else
        w_shiftVec   = r_lanePos;
        w_shiftMoves = 1'b0;
`endif
      end else begin
        w_shiftVec   = {r_lanePos[RegLANE_DATAWIDTH-2:0], 1'b0};
        w_shiftMoves = 1'b1;
      end
    end else if (w_selRight) begin
      if (r_lanePos[0]) begin
`ifdef SC_REGLANE_WRAP_EN
        w_shiftVec   = {r_lanePos[0], r_lanePos[RegLANE_DATAWIDTH-1:1]};
        w_shiftMoves = 1'b1;
`else
        w_shiftVec   = r_lanePos;
        w_shiftMoves = 1'b0;
`endif
      end else begin
        w_shiftVec   = {1'b0, r_lanePos[RegLANE_DATAWIDTH-1:1]};
        w_shiftMoves = 1'b1;
      end
    end
  end

  // Lane register, pulse outputs and the auto-repeat FSM; clear beats load beats steering.
  always_ff @(posedge SC_RegLANE_CLOCK_50 or negedge SC_RegLANE_RESET_InLow) begin
    if (!SC_RegLANE_RESET_InLow) begin
      r_lanePos    <= c_INIT_VEC;
      r_moved      <= 1'b0;
      r_loadErr    <= 1'b0;
      r_state      <= ST_IDLE;
      r_repeatCnt  <= c_CNT_ZERO;
      r_dirLatched <= c_SEL_NONE;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      r_moved   <= 1'b0;
      r_loadErr <= 1'b0;

      if (!SC_RegLANE_clear_InLow) begin
        r_lanePos   <= c_INIT_VEC;
        r_state     <= ST_LOCK;
        r_repeatCnt <= c_CNT_ZERO;
      end else if (!SC_RegLANE_load_InLow) begin
        // A rejected load still locks steering so a held input cannot
        // immediately move the car after a reposition attempt.
        if (w_loadOneHot) begin
          r_lanePos <= SC_RegLANE_data_InBUS;
        end else begin
          r_loadErr <= 1'b1;
        end
        r_state     <= ST_LOCK;
        r_repeatCnt <= c_CNT_ZERO;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_selValid && SC_RegLANE_enable_In) begin
              r_lanePos    <= w_shiftVec;
              r_moved      <= w_shiftMoves;
              r_dirLatched <= SC_RegLANE_shiftselection_In;
              r_repeatCnt  <= c_CNT_ZERO;
              r_state      <= ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (!w_selValid) begin
              r_state <= ST_IDLE;
            end else if (w_dirChange && SC_RegLANE_enable_In) begin
              r_lanePos    <= w_shiftVec;
              r_moved      <= w_shiftMoves;
              r_dirLatched <= SC_RegLANE_shiftselection_In;
              r_repeatCnt  <= c_CNT_ZERO;
            end else if (SC_RegLANE_enable_In && !w_dirChange) begin
              if (r_repeatCnt == c_DELAY_LAST) begin
                r_lanePos   <= w_shiftVec;
                r_moved     <= w_shiftMoves;
                r_repeatCnt <= c_CNT_ZERO;
                r_state     <= ST_REPEAT;
              end else begin
                r_repeatCnt <= r_repeatCnt + 1'b1;
              end
            end
          end

          ST_REPEAT: begin
            if (!w_selValid) begin
              r_state <= ST_IDLE;
            end else if (w_dirChange && SC_RegLANE_enable_In) begin
              // Reversing while repeating restarts the initial delay.
              r_lanePos    <= w_shiftVec;
              r_moved      <= w_shiftMoves;
              r_dirLatched <= SC_RegLANE_shiftselection_In;
              r_repeatCnt  <= c_CNT_ZERO;
              r_state      <= ST_HOLD;
            end else if (SC_RegLANE_enable_In && !w_dirChange) begin
              if (r_repeatCnt == c_PERIOD_LAST) begin
                r_lanePos   <= w_shiftVec;
                r_moved     <= w_shiftMoves;
                r_repeatCnt <= c_CNT_ZERO;
              end else begin
                r_repeatCnt <= r_repeatCnt + 1'b1;
              end
            end
          end

          ST_LOCK: begin
            if (!w_selValid) begin
              r_state <= ST_IDLE;
            end
          end

          default: begin
            r_state     <= ST_IDLE;
            r_repeatCnt <= c_CNT_ZERO;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign SC_RegLANE_data_OutBUS = r_lanePos;
  assign SC_RegLANE_moved_Out   = r_moved;
  assign SC_RegLANE_loaderr_Out = r_loadErr;
  assign SC_RegLANE_atlimit_Out = {r_lanePos[RegLANE_DATAWIDTH-1], r_lanePos[0]};

endmodule
`default_nettype wire

// File: tb/tb_sc_reg_lane_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_reg_lane_shifter
//  Brief    : Self-checking bench for sc_reg_lane_shifter (W=8, INIT=3,
//             DELAY=16, PERIOD=4). Expected values follow the build macro
//             SC_REGLANE_WRAP_EN where edge behaviour differs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sc_reg_lane_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_n;
  logic       ld_n;
  logic       en;
  logic [1:0] sel;
  logic [7:0] din;
  logic [7:0] dout;
  logic       moved;
  logic [1:0] atlimit;
  logic       loaderr;

  int nChecks = 0;
  int nFails  = 0;

`ifdef SC_REGLANE_WRAP_EN
  localparam bit c_WRAP = 1'b1;
  localparam logic [7:0] c_SAT_POS   = 8'h80;
  localparam logic       c_SAT_MOVED = 1'b1;
  localparam logic [1:0] c_SAT_LIM   = 2'b10;
`else
  localparam bit c_WRAP = 1'b0;
  localparam logic [7:0] c_SAT_POS   = 8'h01;
  localparam logic       c_SAT_MOVED = 1'b0;
  localparam logic [1:0] c_SAT_LIM   = 2'b01;
`endif

  sc_reg_lane_shifter #(
    .RegLANE_DATAWIDTH    (8),
    .RegLANE_INIT_POS     (3),
    .RegLANE_REPEAT_DELAY (16),
    .RegLANE_REPEAT_PERIOD(4)
  ) dut (
    .SC_RegLANE_CLOCK_50         (clk),
    .SC_RegLANE_RESET_InLow      (rst_n),
    .SC_RegLANE_clear_InLow      (clr_n),
    .SC_RegLANE_load_InLow       (ld_n),
    .SC_RegLANE_enable_In        (en),
    .SC_RegLANE_shiftselection_In(sel),
    .SC_RegLANE_data_InBUS       (din),
    .SC_RegLANE_data_OutBUS      (dout),
    .SC_RegLANE_moved_Out        (moved),
    .SC_RegLANE_atlimit_Out      (atlimit),
    .SC_RegLANE_loaderr_Out      (loaderr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clrN;
    logic       ldN;
    logic       en;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] expPos;
    logic       expMoved;
    logic       expErr;
    logic [1:0] expLim;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addV(input logic c, input logic l, input logic e, input logic [1:0] s,
                      input logic [7:0] d, input logic [7:0] p, input logic m,
                      input logic er, input logic [1:0] lim);
    vec_t v;
    v.clrN = c; v.ldN = l; v.en = e; v.sel = s; v.data = d;
    v.expPos = p; v.expMoved = m; v.expErr = er; v.expLim = lim;
    vecs.push_back(v);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    clr_n = 1'b1; ld_n = 1'b1; en = 1'b1; sel = 2'b00; din = 8'h00;
  endtask

  // Clear to lane 3 and release so the FSM sits in IDLE.
  task automatic clearToIdle();
    idleInputs();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    check("clear_pos", dout, 8'h08);
  endtask

  initial begin
    logic [7:0] pos;
    logic       expM;
    bit         doShift;
    int         enIdx;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    idleInputs();
    #22;
    check("reset_pos", dout, 8'h08);
    check("reset_moved", moved, 1'b0);
    check("reset_lim", atlimit, 2'b00);
    check("reset_err", loaderr, 1'b0);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    //    clr  ld   en   sel    data   pos    mv   err  lim
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h08,1'b0,1'b0,2'b00); // idle
    addV(1'b1,1'b1,1'b1,2'b01,8'h00, 8'h10,1'b1,1'b0,2'b00); // left
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h10,1'b0,1'b0,2'b00); // moved one cycle only
    addV(1'b1,1'b1,1'b0,2'b01,8'h00, 8'h10,1'b0,1'b0,2'b00); // enable low blocks
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h10,1'b0,1'b0,2'b00);
    addV(1'b1,1'b1,1'b1,2'b10,8'h00, 8'h08,1'b1,1'b0,2'b00); // right
    addV(1'b1,1'b1,1'b1,2'b01,8'h00, 8'h10,1'b1,1'b0,2'b00); // reversal in HOLD
    addV(1'b1,1'b1,1'b1,2'b11,8'h00, 8'h10,1'b0,1'b0,2'b00); // 11 = none
    addV(1'b1,1'b0,1'b1,2'b00,8'h06, 8'h10,1'b0,1'b1,2'b00); // bad load
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h10,1'b0,1'b0,2'b00); // loaderr one cycle
    addV(1'b1,1'b0,1'b1,2'b01,8'h01, 8'h01,1'b0,1'b0,2'b01); // load lane 0, left held
    addV(1'b1,1'b1,1'b1,2'b01,8'h00, 8'h01,1'b0,1'b0,2'b01); // LOCK
    addV(1'b1,1'b1,1'b1,2'b01,8'h00, 8'h01,1'b0,1'b0,2'b01); // LOCK
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h01,1'b0,1'b0,2'b01); // release -> IDLE
    addV(1'b1,1'b1,1'b1,2'b10,8'h00, c_SAT_POS,c_SAT_MOVED,1'b0,c_SAT_LIM); // right at lane 0
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, c_SAT_POS,1'b0,1'b0,c_SAT_LIM);
    addV(1'b0,1'b0,1'b1,2'b01,8'h80, 8'h08,1'b0,1'b0,2'b00); // clear+load+left
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h08,1'b0,1'b0,2'b00);
    addV(1'b1,1'b0,1'b1,2'b01,8'h80, 8'h80,1'b0,1'b0,2'b10); // load MSB, left held
    addV(1'b1,1'b1,1'b1,2'b01,8'h00, 8'h80,1'b0,1'b0,2'b10); // LOCK
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h80,1'b0,1'b0,2'b10); // release
    addV(1'b1,1'b1,1'b1,2'b10,8'h00, 8'h40,1'b1,1'b0,2'b00); // right
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h40,1'b0,1'b0,2'b00);
    addV(1'b1,1'b0,1'b1,2'b00,8'h00, 8'h40,1'b0,1'b1,2'b00); // zero load rejected
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h40,1'b0,1'b0,2'b00);
    addV(1'b0,1'b0,1'b1,2'b00,8'h03, 8'h08,1'b0,1'b0,2'b00); // clear masks bad load
    addV(1'b1,1'b1,1'b1,2'b00,8'h00, 8'h08,1'b0,1'b0,2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      clr_n = vecs[i].clrN; ld_n = vecs[i].ldN; en = vecs[i].en;
      sel = vecs[i].sel; din = vecs[i].data;
      tick();
      check($sformatf("vec%0d_pos", i), dout, vecs[i].expPos);
      check($sformatf("vec%0d_moved", i), moved, vecs[i].expMoved);
      check($sformatf("vec%0d_err", i), loaderr, vecs[i].expErr);
      check($sformatf("vec%0d_lim", i), atlimit, vecs[i].expLim);
    end

    // ---------------- left held 40 cycles: shifts at 0,16,20,24,28,... ----------------
    clearToIdle();
    pos = 8'h08;
    sel = 2'b01;
    for (int e = 0; e < 40; e++) begin
      tick();
      doShift = (e == 0) || (e >= 16 && ((e - 16) % 4) == 0);
      expM = 1'b0;
      if (doShift) begin
        if (pos[7]) begin
          if (c_WRAP) begin pos = {pos[6:0], pos[7]}; expM = 1'b1; end
        end else begin
          pos = pos << 1; expM = 1'b1;
        end
      end
      check($sformatf("hold_e%0d_pos", e), dout, pos);
      check($sformatf("hold_e%0d_moved", e), moved, expM);
      check($sformatf("hold_e%0d_lim", e), atlimit, {pos[7], pos[0]});
    end
    sel = 2'b00;
    tick();

    // ---------------- enable gaps freeze the repeat counter ----------------
    clearToIdle();
    pos = 8'h08;
    sel = 2'b01;
    enIdx = 0;
    for (int e = 0; e < 24; e++) begin
      en = !(e >= 1 && e <= 5);
      tick();
      expM = 1'b0;
      if (en) begin
        if (enIdx == 0 || enIdx == 16) begin pos = pos << 1; expM = 1'b1; end
        enIdx++;
      end
      check($sformatf("gate_e%0d_pos", e), dout, pos);
      check($sformatf("gate_e%0d_moved", e), moved, expM);
    end
    en = 1'b1;
    sel = 2'b00;
    tick();

    // ---------------- asynchronous reset mid-REPEAT ----------------
    clearToIdle();
    sel = 2'b01;
    for (int e = 0; e < 22; e++) tick();
    check("mid_repeat_pos", dout, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pos", dout, 8'h08);
    check("async_reset_moved", moved, 1'b0);
    tick();
    check("reset_held_pos", dout, 8'h08);
    rst_n = 1'b1;
    tick();
    check("post_reset_pos", dout, 8'h10);
    check("post_reset_moved", moved, 1'b1);
    sel = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
